// File: rtl/usbdev_pkg.sv
// rtl/usbdev_pkg.sv - shared types and constants for the usbdev AON suspend sequencer
//
// Purpose: state encoding of the AON suspend/resume sequencer and the bit
// positions of the latched wake cause vector.
// Ports: none (package).

package usbdev_pkg;

   typedef enum logic [2:0] {
      AwkSeqIdle       = 3'd0,
      AwkSeqEntering   = 3'd1,
      AwkSeqMonitoring = 3'd2,
      AwkSeqWaking     = 3'd3,
      AwkSeqExiting    = 3'd4
   } awk_seq_state_e;

   // Bit indices inside wake_cause ({sense_lost, bus_reset, bus_not_idle})
   localparam int unsigned WakeCauseNotIdle   = 0;
   localparam int unsigned WakeCauseBusReset  = 1;
   localparam int unsigned WakeCauseSenseLost = 2;
   localparam int unsigned WakeCauseW         = 3;

endpackage

// File: rtl/usbdev_aon_suspend_seq.sv
// rtl/usbdev_aon_suspend_seq.sv - AON suspend/resume handshake sequencer for the wake detector
//
// Purpose: hands the bus over to the AON wake detector on a software suspend
// request, raises the power-manager wake request when the detector reports
// activity, latches the wake cause, and returns control on software
// acknowledge. Times out a detector that fails to take or release control.
// Ports:
//   clk_aon_i, rst_aon_ni     AON clock, async active-low reset
//   sw_suspend_req_i          software suspend pulse (AON-synchronized)
//   sw_wake_ack_i             software wake acknowledge / forced exit pulse
//   wake_detect_active_i      detector currently owns the pullups
//   wake_req_i                detector wake request level
//   bus_not_idle_i, bus_reset_i, sense_lost_i   detector event levels
//   suspend_req_o, wake_ack_o detector handshake outputs
//   pwr_wake_req_o            wake request to the power manager
//   wake_cause_o              latched {sense_lost, bus_reset, bus_not_idle}
//   timeout_err_o             one-cycle pulse on entry/exit timeout
//   state_o                   current state (debug)

module usbdev_aon_suspend_seq
   import usbdev_pkg::*;
#(
   parameter int unsigned EntryTimeout = 16,
   localparam int unsigned TimeoutW = $clog2(EntryTimeout + 1)
) (
   input  logic                  clk_aon_i,
   input  logic                  rst_aon_ni,
   input  logic                  sw_suspend_req_i,
   input  logic                  sw_wake_ack_i,
   input  logic                  wake_detect_active_i,
   input  logic                  wake_req_i,
   input  logic                  bus_not_idle_i,
   input  logic                  bus_reset_i,
   input  logic                  sense_lost_i,
   output logic                  suspend_req_o,
   output logic                  wake_ack_o,
   output logic                  pwr_wake_req_o,
   output logic [WakeCauseW-1:0] wake_cause_o,
   output logic                  timeout_err_o,
   output logic [2:0]            state_o
);

   localparam logic [TimeoutW-1:0] CntLast = TimeoutW'(EntryTimeout - 1);

   awk_seq_state_e        state_q;
   logic [TimeoutW-1:0]   cnt_q;
   logic [TimeoutW-1:0]   cnt_inc;
   logic [WakeCauseW-1:0] events;

   always_comb begin
      events                     = '0;
      events[WakeCauseNotIdle]   = bus_not_idle_i;
      events[WakeCauseBusReset]  = bus_reset_i;
      events[WakeCauseSenseLost] = sense_lost_i;
   end

   // Saturating increment: the counter must never wrap back to zero.
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   assign state_o = state_q;

   // All handshake outputs are registered alongside the state so that an
   // async reset drops them immediately.
   always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
      if (!rst_aon_ni) begin
         state_q        <= AwkSeqIdle;
         cnt_q          <= '0;
         suspend_req_o  <= 1'b0;
         wake_ack_o     <= 1'b0;
         pwr_wake_req_o <= 1'b0;
         wake_cause_o   <= '0;
         timeout_err_o  <= 1'b0;
      end else begin
         timeout_err_o <= 1'b0;
         case (state_q)
            AwkSeqIdle: begin
               if (sw_suspend_req_i) begin
                  state_q       <= AwkSeqEntering;
                  cnt_q         <= '0;
                  wake_cause_o  <= '0;
                  suspend_req_o <= 1'b1;
               end
            end
            AwkSeqEntering: begin
               // Activation beats a coincident timeout.
               if (wake_detect_active_i) begin
                  state_q       <= AwkSeqMonitoring;
                  cnt_q         <= '0;
                  suspend_req_o <= 1'b0;
               end else if (cnt_q == CntLast) begin
                  state_q       <= AwkSeqIdle;
                  cnt_q         <= '0;
                  suspend_req_o <= 1'b0;
                  timeout_err_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            AwkSeqMonitoring: begin
               // A wake request takes priority; a coincident ack is dropped.
               if (wake_req_i) begin
                  state_q        <= AwkSeqWaking;
                  wake_cause_o   <= events;
                  pwr_wake_req_o <= 1'b1;
               end else if (sw_wake_ack_i) begin
                  state_q      <= AwkSeqExiting;
                  cnt_q        <= '0;
                  wake_cause_o <= '0;
                  wake_ack_o   <= 1'b1;
               end
            end
            AwkSeqWaking: begin
               wake_cause_o <= wake_cause_o | events;
               if (sw_wake_ack_i) begin
                  state_q        <= AwkSeqExiting;
                  cnt_q          <= '0;
                  pwr_wake_req_o <= 1'b0;
                  wake_ack_o     <= 1'b1;
               end
            end
            AwkSeqExiting: begin
               if (!wake_detect_active_i) begin
                  state_q    <= AwkSeqIdle;
                  cnt_q      <= '0;
                  wake_ack_o <= 1'b0;
               end else if (cnt_q == CntLast) begin
                  state_q       <= AwkSeqIdle;
                  cnt_q         <= '0;
                  wake_ack_o    <= 1'b0;
                  timeout_err_o <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q        <= AwkSeqIdle;
               cnt_q          <= '0;
               suspend_req_o  <= 1'b0;
               wake_ack_o     <= 1'b0;
               pwr_wake_req_o <= 1'b0;
            end
         endcase
      end
   end

   a_state_known: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
      !$isunknown(state_o));
   a_handshake_excl: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
      !(suspend_req_o && wake_ack_o));
   a_timeout_pulse: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
      timeout_err_o |=> !timeout_err_o);

endmodule

// File: tb/tb_usbdev_aon_suspend_seq.sv
// tb/tb_usbdev_aon_suspend_seq.sv - self-checking bench for usbdev_aon_suspend_seq

module tb_usbdev_aon_suspend_seq;

   localparam int unsigned EntryTimeout = 16;

   logic       clk_aon_i = 1'b0;
   logic       rst_aon_ni;
   logic       sw_suspend_req_i, sw_wake_ack_i, wake_detect_active_i, wake_req_i;
   logic       bus_not_idle_i, bus_reset_i, sense_lost_i;
   logic       suspend_req_o, wake_ack_o, pwr_wake_req_o, timeout_err_o;
   logic [2:0] wake_cause_o, state_o;

   int n_checks = 0;
   int n_errors = 0;

   usbdev_aon_suspend_seq #(.EntryTimeout(EntryTimeout)) dut (
      .clk_aon_i            (clk_aon_i),
      .rst_aon_ni           (rst_aon_ni),
      .sw_suspend_req_i     (sw_suspend_req_i),
      .sw_wake_ack_i        (sw_wake_ack_i),
      .wake_detect_active_i (wake_detect_active_i),
      .wake_req_i           (wake_req_i),
      .bus_not_idle_i       (bus_not_idle_i),
      .bus_reset_i          (bus_reset_i),
      .sense_lost_i         (sense_lost_i),
      .suspend_req_o        (suspend_req_o),
      .wake_ack_o           (wake_ack_o),
      .pwr_wake_req_o       (pwr_wake_req_o),
      .wake_cause_o         (wake_cause_o),
      .timeout_err_o        (timeout_err_o),
      .state_o              (state_o)
   );

   always #5 clk_aon_i = ~clk_aon_i;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_aon_i);
      #1;
   endtask

   task automatic set_events(input logic [2:0] ev);
      bus_not_idle_i = ev[0];
      bus_reset_i    = ev[1];
      sense_lost_i   = ev[2];
   endtask

   task automatic enter_monitoring(input int d);
      sw_suspend_req_i = 1'b1;
      tick();
      sw_suspend_req_i = 1'b0;
      check("enter_suspend_req", suspend_req_o, 1);
      check("enter_state", state_o, 1);
      check("enter_cause_clear", wake_cause_o, 0);
      repeat (d) tick();
      wake_detect_active_i = 1'b1;
      tick();
      check("mon_state", state_o, 2);
      check("mon_suspend_req", suspend_req_o, 0);
   endtask

   task automatic run_timeout(input string tag, input int exp_busy_state);
      for (int i = 1; i <= int'(EntryTimeout); i++) begin
         sw_wake_ack_i = (exp_busy_state == 1 && i == 5);
         tick();
         sw_wake_ack_i = 1'b0;
         check({tag, "_err"}, timeout_err_o, (i == int'(EntryTimeout)) ? 1 : 0);
         check({tag, "_state"}, state_o, (i == int'(EntryTimeout)) ? 0 : exp_busy_state);
         check({tag, "_pwr"}, pwr_wake_req_o, 0);
      end
      check({tag, "_sreq_low"}, suspend_req_o, 0);
      check({tag, "_ack_low"}, wake_ack_o, 0);
      tick();
      check({tag, "_err_single"}, timeout_err_o, 0);
   endtask

   initial begin
      logic [2:0] ev;
      logic [2:0] cause_exp;
      int d;
      int n;

      rst_aon_ni = 1'b0;
      sw_suspend_req_i = 1'b0;
      sw_wake_ack_i = 1'b0;
      wake_detect_active_i = 1'b0;
      wake_req_i = 1'b0;
      set_events(3'b000);
      repeat (2) @(posedge clk_aon_i);
      #3;
      check("rst_state", state_o, 0);
      check("rst_outputs", {suspend_req_o, wake_ack_o, pwr_wake_req_o, timeout_err_o}, 0);
      check("rst_cause", wake_cause_o, 0);
      rst_aon_ni = 1'b1;
      tick();
      check("idle_state", state_o, 0);

      // Normal sequence: detector active 3 cycles later, bus reset wake.
      enter_monitoring(3);
      set_events(3'b010);
      wake_req_i = 1'b1;
      tick();
      check("norm_pwr", pwr_wake_req_o, 1);
      check("norm_cause", wake_cause_o, 3'b010);
      check("norm_state", state_o, 3);
      wake_req_i = 1'b0;
      set_events(3'b000);
      tick();
      check("norm_cause_hold", wake_cause_o, 3'b010);
      sw_wake_ack_i = 1'b1;
      tick();
      sw_wake_ack_i = 1'b0;
      check("norm_wake_ack", wake_ack_o, 1);
      check("norm_pwr_drop", pwr_wake_req_o, 0);
      check("norm_exit_state", state_o, 4);
      wake_detect_active_i = 1'b0;
      tick();
      check("norm_idle", state_o, 0);
      check("norm_ack_drop", wake_ack_o, 0);
      check("norm_cause_in_idle", wake_cause_o, 3'b010);

      sw_wake_ack_i = 1'b1;
      tick();
      sw_wake_ack_i = 1'b0;
      check("idle_ack_ignored", state_o, 0);

      // Entry timeout, with an ack in Entering that must be ignored.
      sw_suspend_req_i = 1'b1;
      tick();
      sw_suspend_req_i = 1'b0;
      check("to_cause_clear", wake_cause_o, 0);
      check("to_sreq", suspend_req_o, 1);
      run_timeout("entry_to", 1);

      // Software exit, then exit timeout with detector stuck active.
      d = $urandom_range(0, EntryTimeout - 3);
      enter_monitoring(d);
      sw_suspend_req_i = 1'b1;
      tick();
      sw_suspend_req_i = 1'b0;
      check("mon_suspend_ignored", state_o, 2);
      sw_wake_ack_i = 1'b1;
      tick();
      sw_wake_ack_i = 1'b0;
      check("swexit_state", state_o, 4);
      check("swexit_ack", wake_ack_o, 1);
      check("swexit_cause", wake_cause_o, 0);
      check("swexit_pwr", pwr_wake_req_o, 0);
      run_timeout("exit_to", 4);
      wake_detect_active_i = 1'b0;

      // Randomized wake rounds; round 0 has a coincident ack.
      for (int r = 0; r < 5; r++) begin
         d = $urandom_range(0, EntryTimeout - 3);
         enter_monitoring(d);
         ev = 3'($urandom);
         set_events(ev);
         wake_req_i = 1'b1;
         sw_wake_ack_i = (r == 0);
         tick();
         wake_req_i = 1'b0;
         sw_wake_ack_i = 1'b0;
         cause_exp = ev;
         check("rnd_wake_state", state_o, 3);
         check("rnd_no_ack", wake_ack_o, 0);
         check("rnd_cause_first", wake_cause_o, cause_exp);
         n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++) begin
            ev = 3'($urandom);
            set_events(ev);
            tick();
            cause_exp = cause_exp | ev;
            check("rnd_cause_sticky", wake_cause_o, cause_exp);
            check("rnd_pwr", pwr_wake_req_o, 1);
         end
         set_events(3'b000);
         sw_wake_ack_i = 1'b1;
         tick();
         sw_wake_ack_i = 1'b0;
         check("rnd_exit_state", state_o, 4);
         wake_detect_active_i = 1'b0;
         tick();
         check("rnd_idle", state_o, 0);
         check("rnd_cause_final", wake_cause_o, cause_exp);
      end

      // Sticky cause: bus_not_idle then sense_lost.
      enter_monitoring(2);
      set_events(3'b001);
      wake_req_i = 1'b1;
      tick();
      wake_req_i = 1'b0;
      check("sticky_first", wake_cause_o, 3'b001);
      set_events(3'b100);
      tick();
      check("sticky_101", wake_cause_o, 3'b101);

      // Async reset mid-Waking.
      #2;
      rst_aon_ni = 1'b0;
      #1;
      check("mrst_state", state_o, 0);
      check("mrst_outputs", {suspend_req_o, wake_ack_o, pwr_wake_req_o, timeout_err_o}, 0);
      check("mrst_cause", wake_cause_o, 0);
      set_events(3'b000);
      wake_detect_active_i = 1'b0;
      repeat (2) @(posedge clk_aon_i);
      @(negedge clk_aon_i);
      rst_aon_ni = 1'b1;
      tick();
      check("post_rst_idle", state_o, 0);
      enter_monitoring(1);
      sw_wake_ack_i = 1'b1;
      tick();
      sw_wake_ack_i = 1'b0;
      wake_detect_active_i = 1'b0;
      tick();
      check("post_rst_done", state_o, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/usbdev_aon_suspend_seq.md
# usbdev_aon_suspend_seq

Always-on sequencer that drives the suspend/resume handshake of the USB AON wake detector. It accepts software suspend and wake-acknowledge pulses, already synchronized into the AON domain, and drives the detector's suspend request and wake acknowledge. It raises the power-manager wake request and latches the wake cause. It also times out a detector that fails to take or release control. It sits between the usbdev register CDC and the AON wake detector, entirely in the AON clock domain.

## Interface
- EntryTimeout, 16: AON cycles allowed for the detector to respond (enter or exit); minimum 2.
- TimeoutW, $clog2(EntryTimeout+1): timeout counter width (derived).
- clk_aon_i  in  1  AON clock (~200 kHz).
- rst_aon_ni  in  1  async active-low reset. One clock; reset is asynchronous and active-low.
- sw_suspend_req_i  in  1  single-cycle pulse: software requests suspend hand-off.
- sw_wake_ack_i  in  1  single-cycle pulse: software acknowledges wake / forces exit.
- wake_detect_active_i  in  1  detector owns the pullups.
- wake_req_i  in  1  detector wake request (level).
- bus_not_idle_i, bus_reset_i, sense_lost_i  in  1 each  detector event levels.
- suspend_req_o  out  1  to detector suspend request.
- wake_ack_o  out  1  to detector wake acknowledge.
- pwr_wake_req_o  out  1  wake request to power manager.
- wake_cause_o  out  3  latched {sense_lost, bus_reset, bus_not_idle}.
- timeout_err_o  out  1  single-cycle pulse on entry/exit timeout.
- state_o  out  3  current state encoding (debug).

## Operation
- States: Idle, Entering, Monitoring, Waking, Exiting.
- Idle: all outputs low. sw_suspend_req_i -> Entering; clear wake_cause and timeout counter.
- Entering: suspend_req_o=1. When wake_detect_active_i=1 -> Monitoring. When the counter reaches EntryTimeout-1 without activation -> Idle with timeout_err_o.
- Monitoring: suspend_req_o=0. When wake_req_i=1 -> Waking; latch wake_cause from the three event inputs in the same cycle. When sw_wake_ack_i=1 with no wake_req_i -> Exiting with cause 000 (software exit). If both fire together, wake_req_i wins and the ack is dropped.
- Waking: pwr_wake_req_o=1. OR newly asserted events into wake_cause (sticky). sw_wake_ack_i -> Exiting.
- Exiting: wake_ack_o=1. Counter restarts at 0. When wake_detect_active_i=0 -> Idle. On timeout -> Idle with timeout_err_o.
- sw_suspend_req_i outside Idle is ignored. sw_wake_ack_i in Idle/Entering is ignored.
- wake_cause holds its value through Idle until the next suspend request.
- Counter saturates and never wraps. It is cleared on every state change.

## Timing
- All outputs are registered: they change the cycle after the causing input is sampled.
- Reset values: state Idle (state_o=0). suspend_req_o, wake_ack_o, pwr_wake_req_o and timeout_err_o are 0. wake_cause_o is 000.
- Suspend request to suspend_req_o high: 1 cycle.
- Detector active to Monitoring: 1 cycle.
- wake_req_i to pwr_wake_req_o: 1 cycle.
- Timeout: exactly EntryTimeout cycles in Entering/Exiting, then the error pulse and Idle in the same edge.
- Async reset mid-sequence forces Idle immediately. The detector sees suspend_req_o/wake_ack_o drop asynchronously.

## Structure
- usbdev_pkg gains:
  - awk_seq_state_e: 3-bit enum, Idle=0, Entering=1, Monitoring=2, Waking=3, Exiting=4.
  - WakeCauseNotIdle/BusReset/SenseLost bit-index constants.
- Single module, no sub-modules. FSM, counter and cause register are inline.
- Assertions:
  - state_o known after reset.
  - suspend_req_o and wake_ack_o never both high.
  - timeout_err_o is a single-cycle pulse.

## Test plan
- Normal sequence, EntryTimeout=16: suspend pulse. Detector asserts active 3 cycles later -> Monitoring. bus_reset_i and wake_req_i high -> pwr_wake_req_o=1 next cycle, wake_cause_o=010. sw_wake_ack_i -> wake_ack_o=1. Active drops -> Idle.
- Entry timeout: suspend pulse, detector never activates -> exactly 16 cycles later timeout_err_o=1 for one cycle, state Idle, suspend_req_o=0.
- Software exit: in Monitoring, sw_wake_ack_i with no events -> Exiting, wake_cause_o=000, pwr_wake_req_o never asserted.
- Simultaneous: wake_req_i and sw_wake_ack_i in the same Monitoring cycle -> Waking, ack ignored, a second ack required to exit.
- Sticky cause: in Waking, sense_lost_i rises after bus_not_idle_i -> wake_cause_o=101.
- Reset mid-Waking: rst_aon_ni low -> all outputs 0 immediately, state_o=0. After release, a suspend pulse restarts cleanly.
